cursor_input: RTL

- Upstream stage of the game-play block. Turns raw board push-buttons (up/down/left/right/center) into a registered 8x8 cursor position and a one-cycle select pulse.
- Synchronises, debounces and edge-detects each button. A held direction button auto-repeats.
- Outputs cursor_x, cursor_y and is_pressed feed the play logic directly. The move/select effect applies only while the game state is PLAY.

---
 rtl/cursor_input_pkg.sv | 12 +
 rtl/cursor_input_btn_debounce.sv | 83 ++++++++
 rtl/cursor_input.sv | 86 ++++++++
 3 files changed

// File: rtl/cursor_input_pkg.sv
// Shared constants for the game-play block: game states and board geometry.
package cursor_input_pkg;

  localparam logic [1:0] ST_PLAY   = 2'b01;
  localparam logic [1:0] ST_SETTLE = 2'b10;

  localparam int BOARD_DIM = 8;
  localparam int COORD_W   = 4;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/cursor_input_btn_debounce.sv
// One push-button: 2-flop synchroniser, debouncer, rising-edge pulse and an
// optional auto-repeat pulse that fires while the debounced level stays high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic rpt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] db_cnt;
  logic            level_q;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level, so any glitch shorter than DEBOUNCE_CYCLES restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync    <= '0;
      db_cnt  <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      if (sync[1] != level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level  <= sync[1];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW      = $clog2(RPT_MAX + 1);

      logic [RW-1:0] rcnt;
      logic          first_done;
      logic          hit;

      // rcnt counts cycles since the last step (edge or repeat) of this press.
      assign hit = level && !rise &&
                   (rcnt == (first_done ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rcnt       <= '0;
          first_done <= 1'b0;
        end else if (!level) begin
          rcnt       <= '0;
          first_done <= 1'b0;
        end else if (rise || hit) begin
          rcnt       <= RW'(1);
          first_done <= hit | first_done;
        end else if (rcnt != RW'(RPT_MAX)) begin
          rcnt <= rcnt + RW'(1);
        end
      end

      assign rpt = hit;
    end else begin : g_no_rpt
      assign rpt = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cursor_input.sv
// Board push-buttons to a registered 8x8 cursor position and a one-cycle
// select pulse; moves and selects only take effect in the PLAY state.
module cursor_input
  import cursor_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000,
  parameter int BOARD_MAX       = 7,
  parameter bit WRAP            = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         state,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_center,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               is_pressed
);

  logic u_lvl, u_rise, u_rpt;
  logic d_lvl, d_rise, d_rpt;
  logic l_lvl, l_rise, l_rpt;
  logic r_lvl, r_rise, r_rpt;
  logic c_lvl, c_rise, c_rpt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
    u_up    (.clk(clk), .rstn(rstn), .btn(btn_up),     .level(u_lvl), .rise(u_rise), .rpt(u_rpt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
    u_down  (.clk(clk), .rstn(rstn), .btn(btn_down),   .level(d_lvl), .rise(d_rise), .rpt(d_rpt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
    u_left  (.clk(clk), .rstn(rstn), .btn(btn_left),   .level(l_lvl), .rise(l_rise), .rpt(l_rpt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
    u_right (.clk(clk), .rstn(rstn), .btn(btn_right),  .level(r_lvl), .rise(r_rise), .rpt(r_rpt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
    u_center(.clk(clk), .rstn(rstn), .btn(btn_center), .level(c_lvl), .rise(c_rise), .rpt(c_rpt));

  function automatic coord_t coord_inc(input coord_t v);
    if (v >= coord_t'(BOARD_MAX)) return WRAP ? coord_t'(0) : coord_t'(BOARD_MAX);
    return v + coord_t'(1);
  endfunction

  function automatic coord_t coord_dec(input coord_t v);
    if (v == coord_t'(0))        return WRAP ? coord_t'(BOARD_MAX) : coord_t'(0);
    if (v > coord_t'(BOARD_MAX)) return coord_t'(BOARD_MAX);
    return v - coord_t'(1);
  endfunction

  logic play;
  logic x_inc, x_dec, y_inc, y_dec, sel_ev;

  // A step is suppressed whenever the opposing button is also debounced-held,
  // which covers simultaneous edges as well as repeats.
  assign play   = (state == ST_PLAY);
  assign x_inc  = (r_rise | r_rpt) & ~l_lvl;
  assign x_dec  = (l_rise | l_rpt) & ~r_lvl;
  assign y_inc  = (d_rise | d_rpt) & ~u_lvl;
  assign y_dec  = (u_rise | u_rpt) & ~d_lvl;
  assign sel_ev = c_lvl & (c_rise | c_rpt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cursor_x   <= '0;
      cursor_y   <= '0;
      is_pressed <= 1'b0;
    end else if (play) begin
      if (x_inc)      cursor_x <= coord_inc(cursor_x);
      else if (x_dec) cursor_x <= coord_dec(cursor_x);
      if (y_inc)      cursor_y <= coord_inc(cursor_y);
      else if (y_dec) cursor_y <= coord_dec(cursor_y);
      is_pressed <= sel_ev;
    end else begin
      is_pressed <= 1'b0;
    end
  end

endmodule
